// File: rtl/hub75_column_shifter.sv
// Shifts one row/bitplane of RGB565 pixels out to a HUB75 panel, fetching each column from the framebuffer stage.
// Latency: row_start to row_done is SHIFT_PIXEL_WIDTH*(SHIFT_LOAD_CYCLES+3)+1 cycles; each column takes SHIFT_LOAD_CYCLES+3 cycles.
// Backpressure: none; row_start is accepted only in IDLE and ignored while busy. Build macro SHIFTER_REVERSE_COLUMN_EN walks columns W-1..0.
module hub75_column_shifter #(
  parameter int SHIFT_PIXEL_WIDTH     = 64,
  parameter int SHIFT_PIXEL_HEIGHT    = 16,
  parameter int SHIFT_BYTES_PER_PIXEL = 2,
  parameter int SHIFT_LOAD_CYCLES     = 4
) (
  input  logic                                  clk_in,
  input  logic                                  reset,
  input  logic                                  row_start,
  input  logic [$clog2(SHIFT_PIXEL_HEIGHT)-1:0] row_select,
  input  logic [2:0]                            bitplane,
  input  logic [15:0]                           rgb565_top,
  input  logic [15:0]                           rgb565_bottom,
  output logic [$clog2(SHIFT_PIXEL_WIDTH)-1:0]  column_address,
  output logic [$clog2(SHIFT_PIXEL_HEIGHT)-1:0] row_address,
  output logic                                  pixel_load_start,
  output logic                                  hub75_clk,
  output logic [2:0]                            rgb1,
  output logic [2:0]                            rgb2,
  output logic                                  busy,
  output logic                                  row_done
);

  localparam int CW       = $clog2(SHIFT_PIXEL_WIDTH);
  localparam int PIX_BITS = SHIFT_BYTES_PER_PIXEL * 8;

`ifdef SHIFTER_REVERSE_COLUMN_EN
  localparam logic [CW-1:0] FIRST_COL = CW'(SHIFT_PIXEL_WIDTH - 1);
  localparam logic [CW-1:0] LAST_COL  = '0;
`else
  localparam logic [CW-1:0] FIRST_COL = '0;
  localparam logic [CW-1:0] LAST_COL  = CW'(SHIFT_PIXEL_WIDTH - 1);
`endif

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETUP, CLOCK, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [2:0]  plane;
  logic [2:0]  rgb1_reg;
  logic [2:0]  rgb2_reg;
  logic        last_col;

  // Pick one bit per channel for the plane; green uses its 5 MSBs so all channels share the 0..4 plane range.
  function automatic logic [2:0] extract(input logic [PIX_BITS-1:0] pix, input logic [2:0] p);
    logic [3:0] pi;
    pi = {1'b0, p};
    if (p > 3'd4) return 3'b000;
    return {pix[4'd11 + pi], pix[4'd6 + pi], pix[pi]};
  endfunction

  assign last_col = (column_address == LAST_COL);
  assign rgb1     = rgb1_reg;
  assign rgb2     = rgb2_reg;

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and Moore outputs decoded from the current state.
  always_comb begin
    state_next       = state;
    pixel_load_start = 1'b0;
    hub75_clk        = 1'b0;
    busy             = 1'b0;
    row_done         = 1'b0;
    case (state)
      IDLE: begin
        if (row_start) state_next = ISSUE;
      end
      ISSUE: begin
        pixel_load_start = 1'b1;
        busy             = 1'b1;
        state_next       = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == 4'd1) state_next = SETUP;
      end
      SETUP: begin
        busy       = 1'b1;
        state_next = CLOCK;
      end
      CLOCK: begin
        hub75_clk  = 1'b1;
        busy       = 1'b1;
        state_next = last_col ? DONE : ISSUE;
      end
      DONE: begin
        row_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture row/plane, fetch-wait countdown, pixel sampling and column stepping.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      column_address <= '0;
      row_address    <= '0;
      plane          <= '0;
      wait_cnt       <= '0;
      rgb1_reg       <= '0;
      rgb2_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (row_start) begin
            row_address    <= row_select;
            plane          <= bitplane;
            column_address <= FIRST_COL;
          end
        end
        ISSUE: wait_cnt <= 4'(SHIFT_LOAD_CYCLES);
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          // The fetch stage's data is valid exactly SHIFT_LOAD_CYCLES cycles after the request.
          if (wait_cnt == 4'd1) begin
            rgb1_reg <= extract(rgb565_top, plane);
            rgb2_reg <= extract(rgb565_bottom, plane);
          end
        end
        CLOCK: begin
          if (!last_col) begin
`ifdef SHIFTER_REVERSE_COLUMN_EN
            column_address <= column_address - CW'(1);
`else
            column_address <= column_address + CW'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_column_shifter.sv
// Bench for hub75_column_shifter: fetch-stage model with randomized pixels and noise outside the sample slot.
// Checks column order/spacing, per-column RGB bits at each shift-clock rise, row latency, busy/row_done handshake.
// Covers reset mid-row, ignored row_start while busy and in the DONE cycle, and the out-of-range bitplane.
module tb_hub75_column_shifter;

  localparam int W      = 64;
  localparam int H      = 16;
  localparam int L      = 4;
  localparam int PERIOD = L + 3;
  localparam int LAT    = W * PERIOD + 1;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        row_start = 1'b0;
  logic [3:0]  row_select = '0;
  logic [2:0]  bitplane = '0;
  logic [15:0] rgb565_top = '0;
  logic [15:0] rgb565_bottom = '0;
  logic [5:0]  column_address;
  logic [3:0]  row_address;
  logic        pixel_load_start;
  logic        hub75_clk;
  logic [2:0]  rgb1;
  logic [2:0]  rgb2;
  logic        busy;
  logic        row_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] top_mem [W];
  logic [15:0] bot_mem [W];
  bit          const_mode = 1'b0;
  int          pend_cnt = -1;
  int          pend_col = 0;

  hub75_column_shifter #(
    .SHIFT_PIXEL_WIDTH(W), .SHIFT_PIXEL_HEIGHT(H),
    .SHIFT_BYTES_PER_PIXEL(2), .SHIFT_LOAD_CYCLES(L)
  ) dut (
    .clk_in(clk_in), .reset(reset), .row_start(row_start), .row_select(row_select),
    .bitplane(bitplane), .rgb565_top(rgb565_top), .rgb565_bottom(rgb565_bottom),
    .column_address(column_address), .row_address(row_address),
    .pixel_load_start(pixel_load_start), .hub75_clk(hub75_clk),
    .rgb1(rgb1), .rgb2(rgb2), .busy(busy), .row_done(row_done)
  );

  always #5 clk_in = ~clk_in;

  // Fetch-stage model: real pixel only during the cycle L after the request, noise otherwise.
  always @(negedge clk_in) begin
    if (pixel_load_start) begin
      pend_cnt = L;
      pend_col = int'(column_address);
    end else if (pend_cnt >= 0) begin
      pend_cnt = pend_cnt - 1;
    end
    if (const_mode) begin
      rgb565_top    = 16'hF800;
      rgb565_bottom = 16'h07E0;
    end else if (pend_cnt == 0) begin
      rgb565_top    = top_mem[pend_col];
      rgb565_bottom = bot_mem[pend_col];
    end else begin
      rgb565_top    = 16'($urandom);
      rgb565_bottom = 16'($urandom);
    end
  end

  // Expected panel bits: R from the red field, G from the top 5 green bits, B from the blue field.
  function automatic logic [2:0] exp_rgb(input logic [15:0] pix, input int plane);
    int v, r, g, b;
    if (plane > 4) return 3'b000;
    v = int'(pix);
    r = (v / (1 << (11 + plane))) % 2;
    g = (v / (1 << (6 + plane))) % 2;
    b = (v / (1 << plane)) % 2;
    return 3'(r * 4 + g * 2 + b);
  endfunction

  // Column visited at position j of the walk.
  function automatic int col_of(input int j);
`ifdef SHIFTER_REVERSE_COLUMN_EN
    return W - 1 - j;
`else
    return j;
`endif
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < W; i++) begin
      top_mem[i] = 16'($urandom);
      bot_mem[i] = 16'($urandom);
    end
  endtask

  // mode 0: plain row; mode 1: extra row_start at k=10 and k=300; mode 2: row_start in the DONE cycle.
  task automatic run_row(input int row, input int plane, input int mode);
    int k, loads, rises, dones, done_k, c;
    bit prev_clk, row_ok, busy_seen;
    logic [2:0] e1, e2;
    logic [15:0] pt, pb;
    loads = 0; rises = 0; dones = 0; done_k = -1; prev_clk = 1'b0; row_ok = 1'b1; busy_seen = 1'b0;
    @(negedge clk_in);
    row_select = 4'(row);
    bitplane   = 3'(plane);
    row_start  = 1'b1;
    k = 0;
    while (k < LAT + 20) begin
      @(negedge clk_in);
      k++;
      row_start  = 1'b0;
      row_select = 4'($urandom);
      bitplane   = 3'($urandom);
      if ((mode == 1 && (k == 10 || k == 300)) || (mode == 2 && k == LAT)) row_start = 1'b1;
      if (k == 1) busy_seen = busy;
      if (pixel_load_start) begin
        checks++;
        if (int'(column_address) != col_of(loads % W) || k != 1 + loads * PERIOD) begin
          failures++;
          $display("FAIL load_col: load %0d at k=%0d col=%0d, required col=%0d at k=%0d",
                   loads, k, column_address, col_of(loads % W), 1 + loads * PERIOD);
        end
        loads++;
      end
      if (hub75_clk && !prev_clk) begin
        c  = col_of(rises % W);
        pt = const_mode ? 16'hF800 : top_mem[c];
        pb = const_mode ? 16'h07E0 : bot_mem[c];
        e1 = exp_rgb(pt, plane);
        e2 = exp_rgb(pb, plane);
        checks++;
        if (rgb1 !== e1 || rgb2 !== e2) begin
          failures++;
          $display("FAIL rgb: col %0d plane %0d rgb1=%b rgb2=%b, required %b %b", c, plane, rgb1, rgb2, e1, e2);
        end
        rises++;
      end
      prev_clk = hub75_clk;
      if (row_address !== 4'(row)) row_ok = 1'b0;
      if (row_done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
    end
    checks++;
    if (busy_seen !== 1'b1) begin failures++; $display("FAIL busy_start: busy=%b, required 1", busy_seen); end
    checks++;
    if (done_k != LAT) begin failures++; $display("FAIL latency: row_done at %0d, required %0d", done_k, LAT); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL done_count: %0d row_done pulses, required 1", dones); end
    checks++;
    if (rises != W) begin failures++; $display("FAIL clk_rises: %0d, required %0d", rises, W); end
    checks++;
    if (loads != W) begin failures++; $display("FAIL load_count: %0d, required %0d", loads, W); end
    checks++;
    if (!row_ok) begin failures++; $display("FAIL row_address: changed during row, required %0d", row); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_end: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({busy, row_done, hub75_clk, pixel_load_start, rgb1, rgb2, column_address, row_address} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b clk=%b load=%b rgb1=%b rgb2=%b col=%0d row=%0d, required all 0",
               busy, row_done, hub75_clk, pixel_load_start, rgb1, rgb2, column_address, row_address);
    end
  endtask

  task automatic test_basic_row();
    fill_mem();
    run_row(5, 0, 0);
  endtask

  task automatic test_random_rows();
    for (int i = 0; i < 3; i++) begin
      fill_mem();
      run_row(int'($urandom_range(H - 1, 0)), int'($urandom_range(4, 0)), 0);
    end
  endtask

  task automatic test_const_planes();
    const_mode = 1'b1;
    run_row(3, 4, 0);
    run_row(9, 5, 0);
    const_mode = 1'b0;
  endtask

  task automatic test_busy_ignore();
    fill_mem();
    run_row(7, 2, 1);
    fill_mem();
    run_row(2, 1, 2);
    fill_mem();
    run_row(12, 3, 0);
  endtask

  task automatic test_reset_mid_row();
    int dones;
    bit idle_ok;
    fill_mem();
    @(negedge clk_in);
    row_select = 4'd6;
    bitplane   = 3'd1;
    row_start  = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_in);
      row_start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    checks++;
    if ({busy, hub75_clk, row_done, pixel_load_start, rgb1, rgb2, column_address, row_address} !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b clk=%b done=%b load=%b rgb1=%b rgb2=%b col=%0d row=%0d, required all 0",
               busy, hub75_clk, row_done, pixel_load_start, rgb1, rgb2, column_address, row_address);
    end
    dones = 0;
    idle_ok = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk_in);
      if (row_done) dones++;
      if (busy || pixel_load_start) idle_ok = 1'b0;
    end
    checks++;
    if (dones != 0 || !idle_ok) begin
      failures++;
      $display("FAIL reset_quiet: %0d row_done, idle=%b, required 0 and 1", dones, idle_ok);
    end
    fill_mem();
    run_row(6, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_random_rows();
    test_const_planes();
    test_busy_ignore();
    test_reset_mid_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
